// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-image loader: FSM state encoding,
// default frame marker and the running checksum helper.
package inst_loader_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         CSUM_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // Wraparound add of one data byte into the frame checksum.
    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [7:0]        data_byte);
        return acc + data_byte;
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-source and instruction-RAM write-port bundle of the boot-image loader.
// The loader side uses the master modport, the environment the slave modport.
interface inst_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              wren;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, wren, wr_addr, wr_data, cpu_hold, done, err
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, wren, wr_addr, wr_data, cpu_hold, done, err
    );
endinterface

// File: rtl/inst_loader_pack.sv
// Byte-to-word packer: places little-endian bytes into a 32-bit word and
// pulses word_ready on the cycle after the fourth byte of a word arrives.
module inst_loader_pack
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  rx_byte,
    output logic [31:0] word,
    output logic        word_ready,
    output logic        last_byte
);

    logic [1:0]  idx_r;
    logic [31:0] word_r;
    logic        ready_r;

    // Byte index, word assembly and the one-cycle completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r   <= 2'd0;
            word_r  <= 32'd0;
            ready_r <= 1'b0;
        end else begin
            ready_r <= push && (idx_r == 2'd3);
            if (clear) begin
                idx_r <= 2'd0;
            end else if (push) begin
                idx_r <= idx_r + 2'd1;
            end else begin
                idx_r <= idx_r;
            end
            if (push) begin
                case (idx_r)
                    2'd0:    word_r[7:0]   <= rx_byte;
                    2'd1:    word_r[15:8]  <= rx_byte;
                    2'd2:    word_r[23:16] <= rx_byte;
                    2'd3:    word_r[31:24] <= rx_byte;
                    default: word_r        <= word_r;
                endcase
            end else begin
                word_r <= word_r;
            end
        end
    end

    assign word       = word_r;
    assign word_ready = ready_r;
    assign last_byte  = (idx_r == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot-image loader: parses SYNC / length / data / checksum frames from a byte
// stream, writes the words into instruction RAM and holds the core meanwhile.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    inst_loader_if.master bus
);

    localparam int          TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t              state_r;
    state_t              state_nx_s;
    logic                rx_ready_r;
    logic                done_r;
    logic                err_r;
    logic                cpu_hold_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [7:0]          len_lo_r;
    logic [15:0]         len_r;
    logic [15:0]         word_cnt_r;
    logic [CSUM_W-1:0]   csum_r;
    logic [TMO_W-1:0]    tmo_r;

    logic                accept_s;
    logic                is_sync_s;
    logic                restart_s;
    logic                data_push_s;
    logic                tmo_active_s;
    logic                tmo_hit_s;
    logic                done_nx_s;
    logic [15:0]         len_in_s;
    logic                last_word_s;
    logic                pack_ready_s;
    logic                pack_last_s;
    logic [31:0]         pack_word_s;

    assign accept_s     = bus.rx_valid && rx_ready_r;
    assign is_sync_s    = (bus.rx_data == SYNC_BYTE);
    assign restart_s    = accept_s && is_sync_s &&
                          (state_r inside {ST_IDLE, ST_DONE, ST_ERR});
    assign data_push_s  = accept_s && (state_r == ST_DATA);
    assign len_in_s     = {bus.rx_data, len_lo_r};
    assign last_word_s  = (word_cnt_r == (len_r - 16'd1));
    assign tmo_active_s = state_r inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CHECK};
    // A byte landing on the expiry cycle wins over the timeout.
    assign tmo_hit_s    = tmo_active_s && !accept_s &&
                          (tmo_r == TMO_W'(TIMEOUT_CYC - 1));

    inst_loader_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart_s),
        .push       (data_push_s),
        .rx_byte    (bus.rx_data),
        .word       (pack_word_s),
        .word_ready (pack_ready_s),
        .last_byte  (pack_last_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode and the done condition.
    always_comb begin
        state_nx_s = state_r;
        done_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (restart_s) state_nx_s = ST_LEN0;
                else           state_nx_s = ST_IDLE;
            end
            ST_LEN0: begin
                if (accept_s)       state_nx_s = ST_LEN1;
                else if (tmo_hit_s) state_nx_s = ST_ERR;
                else                state_nx_s = ST_LEN0;
            end
            ST_LEN1: begin
                if (accept_s) begin
                    if ({1'b0, len_in_s} > MAX_WORDS) state_nx_s = ST_ERR;
                    else if (len_in_s == 16'd0)      state_nx_s = ST_CHECK;
                    else                             state_nx_s = ST_DATA;
                end else if (tmo_hit_s) begin
                    state_nx_s = ST_ERR;
                end else begin
                    state_nx_s = ST_LEN1;
                end
            end
            ST_DATA: begin
                if (accept_s && pack_last_s && last_word_s) state_nx_s = ST_CHECK;
                else if (tmo_hit_s)                         state_nx_s = ST_ERR;
                else                                        state_nx_s = ST_DATA;
            end
            ST_CHECK: begin
                if (accept_s) begin
                    if (bus.rx_data == csum_r) begin
                        state_nx_s = ST_DONE;
                        done_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = ST_ERR;
                    end
                end else if (tmo_hit_s) begin
                    state_nx_s = ST_ERR;
                end else begin
                    state_nx_s = ST_CHECK;
                end
            end
            ST_DONE, ST_ERR: begin
                if (restart_s) state_nx_s = ST_LEN0;
                else           state_nx_s = state_r;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Registered status outputs and the RAM word address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready_r <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            cpu_hold_r <= 1'b1;
            wr_addr_r  <= '0;
        end else begin
            rx_ready_r <= 1'b1;
            done_r     <= done_nx_s;
            err_r      <= (state_nx_s == ST_ERR);
            cpu_hold_r <= (state_nx_s != ST_DONE);
            if (restart_s) begin
                wr_addr_r <= '0;
            end else if (pack_ready_s) begin
                wr_addr_r <= wr_addr_r + ADDR_W'(1);
            end else begin
                wr_addr_r <= wr_addr_r;
            end
        end
    end

    // Frame bookkeeping: length, word count, checksum and inter-byte timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo_r   <= 8'd0;
            len_r      <= 16'd0;
            word_cnt_r <= 16'd0;
            csum_r     <= '0;
            tmo_r      <= '0;
        end else begin
            if (accept_s && (state_r == ST_LEN0)) len_lo_r <= bus.rx_data;
            else                                  len_lo_r <= len_lo_r;

            if (accept_s && (state_r == ST_LEN1)) len_r <= len_in_s;
            else                                  len_r <= len_r;

            if (restart_s)                       word_cnt_r <= 16'd0;
            else if (data_push_s && pack_last_s) word_cnt_r <= word_cnt_r + 16'd1;
            else                                 word_cnt_r <= word_cnt_r;

            if (restart_s)        csum_r <= '0;
            else if (data_push_s) csum_r <= csum_add(csum_r, bus.rx_data);
            else                  csum_r <= csum_r;

            if (!tmo_active_s || accept_s) tmo_r <= '0;
            else                           tmo_r <= tmo_r + TMO_W'(1);
        end
    end

    assign bus.rx_ready = rx_ready_r;
    assign bus.wren     = pack_ready_s;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = pack_word_s;
    assign bus.cpu_hold = cpu_hold_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: good/bad frames, zero and oversize length,
// inter-byte timeout, garbage before SYNC, restart and mid-frame reset.
module tb_inst_loader;

    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_loader #(
        .ADDR_W      (ADDR_W),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    int                wr_n   = 0;
    int                done_n = 0;
    logic [31:0]       log_data [64];
    logic [ADDR_W-1:0] log_addr [64];

    // Record every write strobe and done pulse away from the active edge.
    always @(negedge clk) begin
        if (bus.wren === 1'b1) begin
            if (wr_n < 64) begin
                log_data[wr_n] <= bus.wr_data;
                log_addr[wr_n] <= bus.wr_addr;
            end
            wr_n <= wr_n + 1;
        end
        if (bus.done === 1'b1) done_n <= done_n + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] sum_bytes(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 4; i++) s = s + a[8*i +: 8] + b[8*i +: 8];
        return s;
    endfunction

    initial begin
        int w0;
        int d0;
        logic [7:0] cs;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst          = 1'b1;
        idle(3);
        check_val("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check_val("rst_wren",     32'(bus.wren),     32'd0);
        check_val("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check_val("rst_err",      32'(bus.err),      32'd0);
        check_val("rst_done",     32'(bus.done),     32'd0);
        check_val("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        check_val("rst_wr_data",  bus.wr_data,       32'd0);
        rst = 1'b0;
        idle(2);

        // 78+56+34+12+EF+BE+AD+DE wraps to 8'h4C
        cs = sum_bytes(32'h12345678, 32'hDEADBEEF);
        check_val("csum_model", 32'(cs), 32'h0000004C);

        // garbage before SYNC, then a good two-word image
        w0 = wr_n;
        d0 = done_n;
        send(8'h00); send(8'hFF);
        send(8'hA5); send(8'h02); send(8'h00);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        send(cs);
        idle(3);
        check_val("good_wr_cnt", 32'(wr_n - w0), 32'd2);
        check_val("good_addr0",  32'(log_addr[w0]), 32'd0);
        check_val("good_data0",  log_data[w0], 32'h12345678);
        check_val("good_addr1",  32'(log_addr[w0 + 1]), 32'd1);
        check_val("good_data1",  log_data[w0 + 1], 32'hDEADBEEF);
        check_val("good_done",   32'(done_n - d0), 32'd1);
        check_val("good_hold",   32'(bus.cpu_hold), 32'd0);
        check_val("good_err",    32'(bus.err), 32'd0);
        check_val("good_addr_end", 32'(bus.wr_addr), 32'd2);

        // restart from DONE with a bad checksum; watch write timing
        w0 = wr_n;
        d0 = done_n;
        send(8'hA5);
        check_val("restart_hold", 32'(bus.cpu_hold), 32'd1);
        send(8'h02); send(8'h00);
        send_word(32'h12345678);
        check_val("w0_wren", 32'(bus.wren), 32'd1);
        check_val("w0_addr", 32'(bus.wr_addr), 32'd0);
        check_val("w0_data", bus.wr_data, 32'h12345678);
        send_word(32'hDEADBEEF);
        check_val("w1_wren", 32'(bus.wren), 32'd1);
        check_val("w1_addr", 32'(bus.wr_addr), 32'd1);
        check_val("w1_data", bus.wr_data, 32'hDEADBEEF);
        send(8'h00);
        idle(3);
        check_val("badcs_wr_cnt", 32'(wr_n - w0), 32'd2);
        check_val("badcs_err",    32'(bus.err), 32'd1);
        check_val("badcs_hold",   32'(bus.cpu_hold), 32'd1);
        check_val("badcs_done",   32'(done_n - d0), 32'd0);

        // restart from ERR with an empty image
        w0 = wr_n;
        d0 = done_n;
        send(8'hA5);
        check_val("err_clear", 32'(bus.err), 32'd0);
        send(8'h00); send(8'h00); send(8'h00);
        idle(3);
        check_val("len0_done",  32'(done_n - d0), 32'd1);
        check_val("len0_wren",  32'(wr_n - w0), 32'd0);
        check_val("len0_hold",  32'(bus.cpu_hold), 32'd0);

        // length one past capacity
        w0 = wr_n;
        send(8'hA5); send(8'h01); send(8'h04);
        idle(2);
        check_val("over_err",  32'(bus.err), 32'd1);
        check_val("over_wren", 32'(wr_n - w0), 32'd0);
        check_val("over_hold", 32'(bus.cpu_hold), 32'd1);

        // inter-byte timeout fires after exactly 16 idle cycles
        w0 = wr_n;
        send(8'hA5); send(8'h02); send(8'h00); send(8'h11);
        idle(15);
        check_val("tmo_early", 32'(bus.err), 32'd0);
        idle(1);
        check_val("tmo_fire", 32'(bus.err), 32'd1);
        check_val("tmo_wren", 32'(wr_n - w0), 32'd0);

        // byte arriving on the expiry cycle keeps the frame alive
        send(8'hA5); send(8'h02); send(8'h00);
        idle(15);
        send(8'h22);
        check_val("tmo_race", 32'(bus.err), 32'd0);
        idle(1);
        check_val("tmo_race2", 32'(bus.err), 32'd0);

        // asynchronous reset in the middle of a word
        w0 = wr_n;
        send(8'h33);
        #3;
        rst = 1'b1;
        #1;
        check_val("mid_rst_wren",  32'(bus.wren), 32'd0);
        check_val("mid_rst_hold",  32'(bus.cpu_hold), 32'd1);
        check_val("mid_rst_ready", 32'(bus.rx_ready), 32'd1);
        check_val("mid_rst_addr",  32'(bus.wr_addr), 32'd0);
        idle(2);
        rst = 1'b0;
        send(8'h44); send(8'h55); send(8'h66); send(8'h77);
        idle(3);
        check_val("mid_rst_nowr", 32'(wr_n - w0), 32'd0);
        check_val("mid_rst_err",  32'(bus.err), 32'd0);
        check_val("mid_rst_hold2", 32'(bus.cpu_hold), 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
